// File: rtl/vram_port_arbiter.sv
// Single-port framebuffer BRAM arbiter: display fetch owns every 16th active cycle,
// the write and read requesters share all remaining cycles round-robin.
module vram_port_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              blank,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_out,
  output logic [3:0]        pix,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic              wr_ready,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic [15:0]       rd_data,
  output logic              rd_data_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata
);

  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);

  localparam logic GRANT_READ  = 1'b0;
  localparam logic GRANT_WRITE = 1'b1;

  logic              in_active;
  logic              disp_slot;
  logic              free_slot;
  logic              wr_grant;
  logic              rd_grant;
  logic              last_grant;
  logic [ADDR_W-1:0] fetch_addr;

  logic [2:0]        hs_pipe;
  logic [2:0]        vs_pipe;
  logic [2:0]        bl_pipe;
  logic [2:0]        act_pipe;
  logic [2:0][1:0]   quad_pipe;
  logic [1:0]        disp_pipe;
  logic [1:0]        rd_pipe;
  logic [15:0]       word_reg;

  assign in_active  = (hcount < H_LIM) && (vcount < V_LIM);
  assign disp_slot  = in_active && (hcount[3:0] == 4'd0);
  assign free_slot  = reset_n && !disp_slot;
  assign fetch_addr = ADDR_W'({vcount[9:2], hcount[9:4]});

  // Handshake: a requester holds valid (and stable addr/data) until it sees
  // valid && ready in the same cycle; ready is only raised for a valid request
  // and depends on the counters, both valids and last_grant, never on itself.
  assign wr_grant = free_slot && wr_valid && (!rd_valid || (last_grant == GRANT_READ));
  assign rd_grant = free_slot && rd_valid && (!wr_valid || (last_grant == GRANT_WRITE));
  assign wr_ready = wr_grant;
  assign rd_ready = rd_grant;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      last_grant    <= GRANT_READ;
      rd_pipe       <= '0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      mem_we <= wr_grant;
      if (disp_slot) begin
        mem_addr <= fetch_addr;
      end else if (wr_grant) begin
        mem_addr   <= wr_addr;
        mem_wdata  <= wr_data;
        last_grant <= GRANT_WRITE;
      end else if (rd_grant) begin
        mem_addr   <= rd_addr;
        last_grant <= GRANT_READ;
      end
      // mem_rdata for a read granted at t is present at t+2.
      rd_pipe       <= {rd_pipe[0], rd_grant};
      rd_data_valid <= rd_pipe[1];
      if (rd_pipe[1]) begin
        rd_data <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hs_pipe   <= '0;
      vs_pipe   <= '0;
      bl_pipe   <= '0;
      act_pipe  <= '0;
      quad_pipe <= '0;
      disp_pipe <= '0;
      word_reg  <= '0;
    end else begin
      hs_pipe   <= {hs_pipe[1:0], hsync};
      vs_pipe   <= {vs_pipe[1:0], vsync};
      bl_pipe   <= {bl_pipe[1:0], blank};
      act_pipe  <= {act_pipe[1:0], in_active};
      quad_pipe <= {quad_pipe[1:0], hcount[3:2]};
      disp_pipe <= {disp_pipe[0], disp_slot};
      if (disp_pipe[1]) begin
        word_reg <= mem_rdata;
      end
    end
  end

  assign hsync_out = hs_pipe[2];
  assign vsync_out = vs_pipe[2];
  assign blank_out = bl_pipe[2];
  // Each word covers 4 fb pixels; each fb pixel spans 4 screen pixels.
  assign pix = act_pipe[2] ? word_reg[{quad_pipe[2], 2'b00} +: 4] : 4'd0;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: BRAM model, behavioural port/scanout model with a
// read-result scoreboard, directed scenarios followed by randomized traffic.
module tb_vram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, blank;
  logic        hsync_out, vsync_out, blank_out;
  logic [3:0]  pix;
  logic        wr_valid;
  logic [13:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        rd_valid;
  logic [13:0] rd_addr;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        rd_data_valid;
  logic [13:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  vram_port_arbiter dut (
    .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out), .pix(pix),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // clock / BRAM (write-first, one cycle read latency)
  always #5 clk = ~clk;

  logic [15:0] bram [0:16383];
  always @(posedge clk) begin
    if (mem_we) begin
      bram[mem_addr] <= mem_wdata;
      mem_rdata      <= mem_wdata;
    end else begin
      mem_rdata <= bram[mem_addr];
    end
  end

  // reference model state
  typedef struct packed {
    logic        act;
    logic [1:0]  quad;
    logic        hs;
    logic        vs;
    logic        bl;
    logic [15:0] word;
  } hist_t;

  logic [15:0] shadow [0:16383];
  hist_t       hist [4];
  logic [15:0] m_word;
  logic        m_last_w;
  logic        e_we, e_addr_chk, e_wd_chk;
  logic [13:0] e_addr;
  logic [15:0] e_wdata;
  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];
  int          cyc;
  bit          chk_on;

  int total;
  int bad;

  logic        s_wr_ready, s_rd_ready, s_rd_dv, s_mem_we;
  logic [3:0]  s_pix;
  logic [15:0] s_rd_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_pos(input int h, input int v);
    hcount = 11'(h);
    vcount = 10'(v);
    blank  = !((h < 1024) && (v < 768));
    hsync  = (h >= 1048) && (h < 1184);
    vsync  = (v >= 771) && (v < 777);
  endtask

  // One clock: compare DUT against model mid-cycle, advance model, move to next cycle.
  task automatic tick();
    hist_t e;
    logic  act, dslot, gw, gr;
    logic  exp_dv;
    #4;
    s_wr_ready = wr_ready;
    s_rd_ready = rd_ready;
    s_rd_dv    = rd_data_valid;
    s_mem_we   = mem_we;
    s_pix      = pix;
    s_rd_data  = rd_data;

    act   = (hcount < 11'd1024) && (vcount < 10'd768);
    dslot = act && (hcount[3:0] == 4'd0);
    gw = reset_n && !dslot && wr_valid && (!rd_valid || !m_last_w);
    gr = reset_n && !dslot && rd_valid && (!wr_valid || m_last_w);
    e  = hist[(cyc + 1) & 3];
    exp_dv = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);

    if (chk_on) begin
      chk("mem_we", mem_we, e_we);
      if (e_addr_chk) chk("mem_addr", mem_addr, e_addr);
      if (e_wd_chk) chk("mem_wdata", mem_wdata, e_wdata);
      chk("rd_data_valid", rd_data_valid, exp_dv);
      if (exp_dv) chk("rd_data", rd_data, exp_q[0]);
      chk("hsync_out", hsync_out, e.hs);
      chk("vsync_out", vsync_out, e.vs);
      chk("blank_out", blank_out, e.bl);
      chk("pix", pix, e.act ? e.word[int'(e.quad) * 4 +: 4] : 4'd0);
      chk("wr_ready", wr_ready, gw);
      chk("rd_ready", rd_ready, gr);
    end
    if (exp_dv) begin
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end

    e_we = 1'b0;
    e_addr_chk = 1'b0;
    e_wd_chk = 1'b0;
    if (!reset_n) begin
      e_addr_chk = 1'b1;
      e_addr = '0;
      e_wd_chk = 1'b1;
      e_wdata = '0;
      m_last_w = 1'b0;
      m_word = '0;
      exp_q.delete();
      exp_cyc_q.delete();
      hist[cyc & 3] = '0;
      hist[(cyc - 1) & 3] = '0;
      hist[(cyc - 2) & 3] = '0;
    end else begin
      if (dslot) begin
        e_addr_chk = 1'b1;
        e_addr = {vcount[9:2], hcount[9:4]};
        m_word = shadow[e_addr];
      end else if (gw) begin
        e_we = 1'b1;
        e_addr_chk = 1'b1;
        e_addr = wr_addr;
        e_wd_chk = 1'b1;
        e_wdata = wr_data;
        shadow[wr_addr] = wr_data;
        m_last_w = 1'b1;
      end else if (gr) begin
        e_addr_chk = 1'b1;
        e_addr = rd_addr;
        exp_q.push_back(shadow[rd_addr]);
        exp_cyc_q.push_back(cyc + 3);
        m_last_w = 1'b0;
      end
      hist[cyc & 3] = '{act: act, quad: hcount[3:2], hs: hsync, vs: vsync, bl: blank, word: m_word};
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_rd_dv"}, rd_data_valid, 0);
    chk({tag, "_pix"}, pix, 0);
    chk({tag, "_hsync_out"}, hsync_out, 0);
    chk({tag, "_vsync_out"}, vsync_out, 0);
    chk({tag, "_blank_out"}, blank_out, 0);
  endtask

  int v_lines[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 766, 767, 768, 800};

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    chk_on = 1'b0;
    m_last_w = 1'b0;
    m_word = '0;
    e_we = 1'b0;
    e_addr_chk = 1'b0;
    e_wd_chk = 1'b0;
    e_addr = '0;
    e_wdata = '0;
    for (int i = 0; i < 4; i++) hist[i] = '0;
    for (int i = 0; i < 16384; i++) begin
      bram[i] = '0;
      shadow[i] = '0;
    end
    mem_rdata = '0;
    reset_n = 1'b0;
    wr_valid = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_valid = 1'b0;
    rd_addr = '0;
    set_pos(1100, 780);
    @(posedge clk);
    #1;

    // reset
    tick();
    chk_on = 1'b1;
    tick();
    reset_n = 1'b1;
    check_all_zero("reset");

    // 1: write 0x4321 to word 0 in blanking, then scan out frame start
    wr_valid = 1'b1;
    wr_addr = 14'h0000;
    wr_data = 16'h4321;
    tick();
    chk("t1_wr_ready", s_wr_ready, 1);
    wr_valid = 1'b0;
    tick();
    tick();
    for (int h = 0; h < 20; h++) begin
      set_pos(h, 0);
      tick();
      if (h >= 3 && h <= 18) chk("t1_pix", s_pix, ((h - 3) >> 2) + 1);
    end

    // 2: write presented on a display slot waits one cycle
    set_pos(16, 5);
    wr_valid = 1'b1;
    wr_addr = 14'h0100;
    wr_data = 16'h5a5a;
    tick();
    chk("t2_ready_h16", s_wr_ready, 0);
    set_pos(17, 5);
    tick();
    chk("t2_ready_h17", s_wr_ready, 1);
    chk("t2_we_h17", s_mem_we, 0);
    wr_valid = 1'b0;
    set_pos(18, 5);
    tick();
    chk("t2_we_h18", s_mem_we, 1);
    set_pos(19, 5);
    tick();
    chk("t2_we_h19", s_mem_we, 0);

    // 3: both requesters continuously in blanking right after reset
    set_pos(1100, 780);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    wr_addr = 14'h0200;
    wr_data = 16'h1111;
    rd_addr = 14'h0300;
    for (int i = 0; i < 14; i++) begin
      wr_valid = (i < 10);
      rd_valid = (i < 10);
      set_pos(1100 + i, 780);
      tick();
      chk("t3_wr_ready", s_wr_ready, (i < 10) && (i % 2 == 0));
      chk("t3_rd_ready", s_rd_ready, (i < 10) && (i % 2 == 1));
      chk("t3_rd_dv", s_rd_dv, (i >= 4) && (i <= 12) && (i % 2 == 0));
    end

    // 4: write then read of the same word returns the new data once
    set_pos(1200, 790);
    wr_valid = 1'b1;
    wr_addr = 14'h1234;
    wr_data = 16'hbeef;
    tick();
    chk("t4_wr_ready", s_wr_ready, 1);
    wr_valid = 1'b0;
    rd_valid = 1'b1;
    rd_addr = 14'h1234;
    tick();
    chk("t4_rd_ready", s_rd_ready, 1);
    rd_valid = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      tick();
      chk("t4_rd_dv", s_rd_dv, (j == 3));
      if (j == 3) chk("t4_rd_data", s_rd_data, 16'hbeef);
    end

    // 5: reset two cycles after a read grant drops that read
    rd_valid = 1'b1;
    rd_addr = 14'h1234;
    tick();
    chk("t5_rd_ready", s_rd_ready, 1);
    rd_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    wr_valid = 1'b1;
    wr_addr = 14'h0055;
    wr_data = 16'h7777;
    tick();
    chk("t5_wr_ready_in_reset", s_wr_ready, 0);
    reset_n = 1'b1;
    check_all_zero("t5");
    rd_valid = 1'b1;
    rd_addr = 14'h0300;
    tick();
    chk("t5_first_wr", s_wr_ready, 1);
    chk("t5_first_rd", s_rd_ready, 0);
    chk("t5_dv0", s_rd_dv, 0);
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("t5_dv", s_rd_dv, 0);
    end

    // 6: random requester traffic across active and blanking lines
    s_wr_ready = 1'b0;
    s_rd_ready = 1'b0;
    foreach (v_lines[li]) begin
      for (int h = 0; h < 1344; h++) begin
        set_pos(h, v_lines[li]);
        if (!(wr_valid && !s_wr_ready)) begin
          wr_valid = ($urandom_range(0, 3) != 0);
          wr_addr = ($urandom_range(0, 7) == 0) ? 14'($urandom_range(0, 16383))
                                                : 14'($urandom_range(0, 127));
          wr_data = 16'($urandom);
        end
        if (!(rd_valid && !s_rd_ready)) begin
          rd_valid = ($urandom_range(0, 2) != 0);
          rd_addr = 14'($urandom_range(0, 127));
        end
        tick();
      end
    end
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    set_pos(1100, 780);
    for (int j = 0; j < 5; j++) tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
